// File: rtl/r_bram_rd_sched_pkg.sv
// Shared definitions for the sample-BRAM read scheduler: widths, depth,
// scheduler state encoding and the round-robin pick helper.
package r_bram_rd_sched_pkg;

  localparam int ADDR_WIDTH = 10;   // port-B address is ADDR_WIDTH-1 bits wide
  localparam int BRAM_DEPTH = 512;
  localparam int OCC_WIDTH  = 10;
  localparam int BEAT_WIDTH = 9;

  localparam logic [OCC_WIDTH-1:0] OCC_ONE  = 10'd1;
  localparam logic [OCC_WIDTH-1:0] OCC_FULL = 10'd512;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BURST = 2'd2
  } sched_state_e;

  // Round-robin pick: ptr holds the consumer served last, so on a tie the
  // other consumer wins. Returns a one-hot grant (or zero when nobody asks).
  function automatic logic [1:0] rr_pick(input logic [1:0] elig, input logic ptr);
    logic [1:0] pick;
    case (elig)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = ptr ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/r_bram_addr.sv
// Read-address counter for BRAM port B. Advances once per enabled cycle and
// wraps naturally from DEPTH-1 to 0, so bursts may straddle the wrap.
module r_bram_addr
  import r_bram_rd_sched_pkg::*;
(
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  en,
  output logic [ADDR_WIDTH-2:0] addr
);

  logic [ADDR_WIDTH-2:0] addr_r;

  // Address register: cleared by reset, incremented on each enabled cycle.
  always_ff @(posedge CLK) begin
    if (rst) begin
      addr_r <= 9'd0;
    end else if (en) begin
      addr_r <= addr_r + 9'd1;
    end
  end

  assign addr = addr_r;

endmodule

// File: rtl/r_bram_rd_sched.sv
// Read-side scheduler for the shared sample BRAM: round-robin arbitration of
// two consumers, fixed-length bursts, occupancy tracking and tagging of the
// returning read data with its owner.
module r_bram_rd_sched
  import r_bram_rd_sched_pkg::*;
#(
  parameter int BURST_LEN  = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  wr_commit,
  input  logic [1:0]            req,
  output logic [1:0]            gnt,
  output logic                  busy,
  output logic [ADDR_WIDTH-2:0] ADDR_B,
  output logic                  rd_en,
  output logic                  rd_valid,
  output logic                  rd_id,
  output logic                  rd_last,
  output logic [OCC_WIDTH-1:0]  occupancy,
  output logic                  ovf
);

  sched_state_e           state_r, state_s;
  logic [1:0]             gnt_r;
  logic                   busy_r;
  logic                   rd_en_r;
  logic                   id_r;
  logic                   rr_ptr_r;
  logic [BEAT_WIDTH-1:0]  beat_cnt_r;
  logic [OCC_WIDTH-1:0]   occ_r;
  logic                   ovf_r;
  logic [1:0]             elig_s;
  logic [1:0]             pick_s;
  logic                   last_beat_s;
  logic [RD_LATENCY-1:0]  pv_r;
  logic [RD_LATENCY-1:0]  pid_r;
  logic [RD_LATENCY-1:0]  plast_r;

  // Next-state logic: arbitration in IDLE, one grant cycle, then BURST_LEN reads.
  always_comb begin
    state_s     = state_r;
    pick_s      = 2'b00;
    last_beat_s = 1'b0;
    elig_s      = req & {2{occ_r >= OCC_WIDTH'(BURST_LEN)}};
    case (state_r)
      ST_IDLE: begin
        if (elig_s != 2'b00) begin
          state_s = ST_GRANT;
          pick_s  = rr_pick(elig_s, rr_ptr_r);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        state_s = ST_BURST;
      end
      ST_BURST: begin
        if (beat_cnt_r == BEAT_WIDTH'(BURST_LEN - 1)) begin
          last_beat_s = 1'b1;
          state_s     = ST_IDLE;
        end else begin
          state_s = ST_BURST;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Scheduler registers; outputs are registered from the next-state decode.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      gnt_r      <= 2'b00;
      busy_r     <= 1'b0;
      rd_en_r    <= 1'b0;
      id_r       <= 1'b0;
      rr_ptr_r   <= 1'b1;
      beat_cnt_r <= 9'd0;
    end else begin
      state_r <= state_s;
      gnt_r   <= pick_s;
      busy_r  <= (state_s != ST_IDLE);
      rd_en_r <= (state_s == ST_BURST);
      if (pick_s != 2'b00) begin
        id_r <= pick_s[1];
      end
      if (state_r == ST_GRANT) begin
        beat_cnt_r <= 9'd0;
      end else if (state_r == ST_BURST) begin
        beat_cnt_r <= beat_cnt_r + 9'd1;
      end
      if (last_beat_s) begin
        rr_ptr_r <= id_r;
      end
    end
  end

  // Occupancy: commits add, reads remove; a commit into a full BRAM flags ovf.
  always_ff @(posedge CLK) begin
    if (rst) begin
      occ_r <= 10'd0;
      ovf_r <= 1'b0;
    end else begin
      case ({wr_commit, rd_en_r})
        2'b10: begin
          if (occ_r == OCC_FULL) begin
            ovf_r <= 1'b1;
          end else begin
            occ_r <= occ_r + OCC_ONE;
          end
        end
        2'b01:   occ_r <= occ_r - OCC_ONE;
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Tag pipe: delays {valid, id, last} to line up with BRAM DOUT.
  always_ff @(posedge CLK) begin
    if (rst) begin
      pv_r    <= '0;
      pid_r   <= '0;
      plast_r <= '0;
    end else begin
      pv_r[0]    <= rd_en_r;
      pid_r[0]   <= rd_en_r & id_r;
      plast_r[0] <= last_beat_s;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pv_r[i]    <= pv_r[i-1];
        pid_r[i]   <= pid_r[i-1];
        plast_r[i] <= plast_r[i-1];
      end
    end
  end

  r_bram_addr u_addr (
    .CLK  (CLK),
    .rst  (rst),
    .en   (rd_en_r),
    .addr (ADDR_B)
  );

  assign gnt       = gnt_r;
  assign busy      = busy_r;
  assign rd_en     = rd_en_r;
  assign rd_valid  = pv_r[RD_LATENCY-1];
  assign rd_id     = pid_r[RD_LATENCY-1];
  assign rd_last   = plast_r[RD_LATENCY-1];
  assign occupancy = occ_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_r_bram_rd_sched.sv
// Bench for r_bram_rd_sched: two instances (16-beat/latency 1 and
// 12-beat/latency 2) share stimulus; each is checked every cycle against a
// transaction-level model, plus a directed table and corner sequences.
module tb_r_bram_rd_sched;

  localparam int BL_A = 16, LAT_A = 1;
  localparam int BL_B = 12, LAT_B = 2;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic       wr_commit = 1'b0;
  logic [1:0] req = 2'b00;

  logic [1:0] gnt_a, gnt_b;
  logic       busy_a, busy_b, rd_en_a, rd_en_b;
  logic [8:0] addr_a, addr_b;
  logic       rd_valid_a, rd_valid_b, rd_id_a, rd_id_b, rd_last_a, rd_last_b;
  logic [9:0] occ_a, occ_b;
  logic       ovf_a, ovf_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  r_bram_rd_sched #(.BURST_LEN(BL_A), .RD_LATENCY(LAT_A)) dut_a (
    .CLK(CLK), .rst(rst), .wr_commit(wr_commit), .req(req), .gnt(gnt_a),
    .busy(busy_a), .ADDR_B(addr_a), .rd_en(rd_en_a), .rd_valid(rd_valid_a),
    .rd_id(rd_id_a), .rd_last(rd_last_a), .occupancy(occ_a), .ovf(ovf_a));

  r_bram_rd_sched #(.BURST_LEN(BL_B), .RD_LATENCY(LAT_B)) dut_b (
    .CLK(CLK), .rst(rst), .wr_commit(wr_commit), .req(req), .gnt(gnt_b),
    .busy(busy_b), .ADDR_B(addr_b), .rd_en(rd_en_b), .rd_valid(rd_valid_b),
    .rd_id(rd_id_b), .rd_last(rd_last_b), .occupancy(occ_b), .ovf(ovf_b));

  // Model: words held, beats left in the current burst, who owns it, who was
  // served last, next read address, and a delay line of read tags
  // (0 = nothing, else 1 + 2*id + 4*last).
  typedef struct {
    int occ; bit ovf; int left; bit gnt_now; int owner; int last_srv; int addr;
    int tags[4];
  } model_t;

  model_t m_a, m_b;

  function automatic model_t model_reset();
    model_t n;
    n.occ = 0; n.ovf = 0; n.left = 0; n.gnt_now = 0; n.owner = 0;
    n.last_srv = 1; n.addr = 0;
    for (int k = 0; k < 4; k++) n.tags[k] = 0;
    return n;
  endfunction

  function automatic model_t model_step(model_t m, bit r, bit wr, logic [1:0] rq, int bl);
    model_t n;
    bit rd;
    int elig;
    if (r) return model_reset();
    n  = m;
    rd = (m.left > 0);
    for (int k = 3; k > 0; k--) n.tags[k] = m.tags[k-1];
    n.tags[0] = rd ? (1 + 2 * m.owner + ((m.left == 1) ? 4 : 0)) : 0;
    if (wr && !rd) begin
      if (m.occ == 512) n.ovf = 1; else n.occ = m.occ + 1;
    end else if (!wr && rd) begin
      n.occ = m.occ - 1;
    end
    if (rd) begin
      n.addr = (m.addr + 1) % 512;
      n.left = m.left - 1;
      if (n.left == 0) n.last_srv = m.owner;
    end else if (m.gnt_now) begin
      n.gnt_now = 0;
      n.left = bl;
    end else begin
      elig = (m.occ >= bl) ? int'(rq) : 0;
      if (elig != 0) begin
        n.gnt_now = 1;
        n.owner = (elig == 3) ? (1 - m.last_srv) : ((elig == 1) ? 0 : 1);
      end
    end
    return n;
  endfunction

  // Expected output vector {gnt,busy,rd_en,addr,valid,id,last,occ,ovf}.
  function automatic logic [26:0] model_vec(model_t m, int lat);
    logic [1:0] g;
    int t;
    g = m.gnt_now ? ((m.owner == 1) ? 2'b10 : 2'b01) : 2'b00;
    t = m.tags[lat-1];
    return {g, (m.gnt_now || m.left > 0), (m.left > 0), 9'(m.addr),
            (t % 2 == 1), ((t / 2) % 2 == 1), ((t / 4) % 2 == 1), 10'(m.occ), m.ovf};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock: advance both models with the inputs the DUTs see, then compare.
  task automatic tick();
    @(posedge CLK);
    m_a = model_step(m_a, rst, wr_commit, req, BL_A);
    m_b = model_step(m_b, rst, wr_commit, req, BL_B);
    @(negedge CLK);
    chk("cycle_a", 32'({gnt_a, busy_a, rd_en_a, addr_a, rd_valid_a, rd_id_a, rd_last_a, occ_a, ovf_a}),
        32'(model_vec(m_a, LAT_A)));
    chk("cycle_b", 32'({gnt_b, busy_b, rd_en_b, addr_b, rd_valid_b, rd_id_b, rd_last_b, occ_b, ovf_b}),
        32'(model_vec(m_b, LAT_B)));
  endtask

  typedef struct {
    int         commits;
    logic [1:0] rq;
    logic [1:0] exp_gnt;
    int         exp_occ;
  } vec_t;

  vec_t tbl[6];
  logic [1:0] seen;
  int en_t, v_t;

  initial begin
    m_a = model_reset();
    m_b = model_reset();
    tbl[0] = '{16, 2'b01, 2'b01, 0};
    tbl[1] = '{40, 2'b11, 2'b10, 24};
    tbl[2] = '{0,  2'b11, 2'b01, 8};
    tbl[3] = '{0,  2'b11, 2'b00, 8};
    tbl[4] = '{8,  2'b10, 2'b10, 0};
    tbl[5] = '{0,  2'b01, 2'b00, 0};

    @(negedge CLK);
    tick();
    rst = 1'b0;
    chk("reset_state", 32'({gnt_a, busy_a, rd_en_a, addr_a, rd_valid_a, occ_a, ovf_a}), 32'd0);

    // Directed table on instance A: fill, request, check winner and residue.
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < tbl[i].commits; c++) begin
        wr_commit = 1'b1;
        tick();
      end
      wr_commit = 1'b0;
      req = tbl[i].rq;
      seen = 2'b00;
      for (int c = 0; c < 10 && seen == 2'b00; c++) begin
        tick();
        seen = gnt_a;
      end
      req = 2'b00;
      chk("tbl_gnt", 32'(seen), 32'(tbl[i].exp_gnt));
      for (int c = 0; c < 40 && busy_a; c++) tick();
      chk("tbl_burst_done", 32'(busy_a), 32'd0);
      tick();
      chk("tbl_occ", 32'(occ_a), 32'(tbl[i].exp_occ));
    end

    // Overflow: 513 commits from empty saturate at 512 and set sticky ovf.
    rst = 1'b1; tick(); rst = 1'b0;
    wr_commit = 1'b1;
    for (int c = 0; c < 513; c++) tick();
    chk("ovf_occ", 32'(occ_a), 32'd512);
    chk("ovf_set", 32'(ovf_a), 32'd1);
    wr_commit = 1'b0;
    tick();
    chk("ovf_sticky", 32'(ovf_a), 32'd1);

    // Commit every cycle through a burst: occupancy stays put.
    wr_commit = 1'b1;
    req = 2'b01;
    seen = 2'b00;
    for (int c = 0; c < 10 && seen == 2'b00; c++) begin
      tick();
      seen = gnt_a;
    end
    req = 2'b00;
    chk("const_gnt", 32'(seen), 32'd1);
    for (int c = 0; c < 40 && busy_a; c++) tick();
    chk("const_occ", 32'(occ_a), 32'd512);
    wr_commit = 1'b0;
    tick();

    // Latency on B, then reset A and B mid-burst (beat 5 of A).
    req = 2'b01;
    seen = 2'b00;
    for (int c = 0; c < 10 && seen == 2'b00; c++) begin
      tick();
      seen = gnt_a;
    end
    req = 2'b00;
    en_t = -1; v_t = -1;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (en_t < 0 && rd_en_b) en_t = t;
      if (v_t < 0 && rd_valid_b) v_t = t;
    end
    chk("lat2_gap", 32'(v_t - en_t), 32'd2);
    chk("pre_rst_busy", 32'(busy_a), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_a", 32'({busy_a, rd_en_a, addr_a, rd_valid_a}), 32'd0);
    chk("mid_rst_b", 32'({busy_b, rd_en_b, rd_valid_b}), 32'd0);

    // Random traffic with occasional resets; models check every cycle.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 999) == 0);
      wr_commit = ($urandom_range(0, 9) < 6);
      for (int b = 0; b < 2; b++) begin
        if (req[b] == 1'b0) req[b] = ($urandom_range(0, 7) == 0);
        else if (gnt_a[b] || $urandom_range(0, 29) == 0) req[b] = 1'b0;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
